r_cpu_ctrl: RTL and testbench
=============================

// Module: r_cpu_ctrl
// PURPOSE
//  Multi-cycle control unit for the R-type CPU datapath (PC, IR, register file, ALU, flag register).
//  Sequences each instruction through FETCH/DECODE/EXEC/WB and drives every datapath write enable.
//  Decodes OP/func into the 3-bit ALU operation and traps on illegal encodings or fetch timeout.
//  Sits beside the datapath inside R_CPU; the datapath feeds OP and func back to it.
// PARAMETERS
//  RET_W      16  width of retired-instruction counter (wraps modulo 2^RET_W)
//  FETCH_TMO  8   max cycles in FETCH waiting for imem_ack before timeout trap (1..255)
// PORTS
//  clk        in   1      system clock, all state updates on rising edge
//  rst        in   1      asynchronous, active-high reset
//  run        in   1      1 = execute instructions; sampled in IDLE and at end of WB
//  OP         in   6      opcode field of IR (instr[31:26])
//  func       in   6      function field of IR (instr[5:0])
//  imem_ack   in   1      instruction memory data valid (single-cycle pulse or held)
//  imem_req   out  1      instruction fetch request
//  pc_we      out  1      PC <= PC+4
//  ir_we      out  1      IR <= instruction memory data
//  ab_we      out  1      latch rs/rt register-file reads into ALU_A/ALU_B
//  fr_we      out  1      flag register (ZF, OF) <= ALU flags
//  rf_we      out  1      register file[rd] <= ALU_F
//  alu_op     out  3      ALU operation code
//  busy       out  1      1 whenever state != IDLE and != TRAP
//  trap       out  1      sticky error indicator
//  trap_cause out  2      00 none, 01 illegal instruction, 10 fetch timeout
//  retired    out  RET_W  count of instructions completed WB
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; all enables 0, alu_op=000, trap=0, trap_cause=00,
//   retired=0, timeout counter=0. Takes effect immediately, aborting any instruction in flight.
//  States: IDLE, FETCH, DECODE, EXEC, WB, TRAP (encodings in shared defs).
//  IDLE: outputs idle; run=1 -> FETCH next cycle, else stay.
//  FETCH: imem_req=1; tmo counter increments each cycle. imem_ack=1 -> ir_we=1 and pc_we=1
//   in that same cycle (Mealy, gated by ack), tmo cleared, -> DECODE. If no ack after
//   FETCH_TMO cycles in FETCH -> TRAP, cause=10; no pc_we/ir_we issued.
//  DECODE: ab_we=1. OP!=000000 or func unsupported -> TRAP, cause=01. Else alu_op register
//   loaded from func, -> EXEC. alu_op is held constant through EXEC and WB.
//  EXEC: fr_we=1 -> WB.   WB: rf_we=1, retired+=1 (wraps) -> FETCH if run=1, else IDLE.
//  Latency: 4 cycles per instruction with zero-wait imem (ack in first FETCH cycle).
//  run deasserted mid-instruction: current instruction completes through WB, then IDLE.
//  TRAP: all enables 0, busy=0, trap=1, cause held; exits only via rst; run ignored.
//  Supported func -> alu_op: 100100 AND->000, 100101 OR->001, 100110 XOR->010, 100111 NOR->011,
//   100000 ADD->100, 100010 SUB->101, 101011 SLTU->110, 000100 SLLV->111. All others illegal.
//  Enables are one-hot in time: at most one of ab_we/fr_we/rf_we asserted in any cycle;
//   pc_we and ir_we only ever assert together.
//  All outputs except pc_we/ir_we are registered or decoded from state alone (glitch-free).
// STRUCTURE
//  Shared include r_cpu_defs.vh: state encodings, ALU op codes, func codes, OP_RTYPE=6'b000000,
//   trap cause codes; the datapath ALU uses the same ALU op constants.
//  Sub-module r_cpu_func_dec: combinational func -> {legal, alu_op[2:0]}; FSM, timeout counter
//   and retired counter stay in r_cpu_ctrl.
// TESTING
//  rst=1 for 2 cycles, run=1, imem_ack tied 1, OP=0, func=100000 -> per instruction pattern
//   FETCH(pc_we,ir_we) DECODE(ab_we) EXEC(fr_we) WB(rf_we), alu_op=100, retired 0->1->2.
//  Sweep all 8 legal funcs -> alu_op matches table; func=001000 -> trap=1, cause=01 after DECODE,
//   no fr_we/rf_we, retired unchanged; run toggled -> still in TRAP until rst.
//  OP=000010 with func=100000 -> TRAP, cause=01.
//  imem_ack held 0 -> imem_req high exactly FETCH_TMO=8 cycles, then trap, cause=10; ack after
//   3 waits -> no trap, pc_we single pulse on the ack cycle.
//  run dropped during EXEC -> rf_we still asserted in WB, retired increments, then IDLE, busy=0.
//  rst pulsed asynchronously mid-EXEC (between edges) -> fr_we and busy drop immediately,
//   retired=0; RET_W=4 run 17 instructions -> retired wraps to 1.

Source files
------------

// File: rtl/r_cpu_ctrl_pkg.sv
// Shared definitions for the R-type CPU control unit and datapath:
// FSM state encodings, ALU operation codes, R-type func codes and trap causes.
package r_cpu_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_WB     = 3'd4,
      ST_TRAP   = 3'd5
   } state_t;

   // ALU operation codes, shared with the datapath ALU
   localparam logic [2:0] ALU_AND  = 3'b000;
   localparam logic [2:0] ALU_OR   = 3'b001;
   localparam logic [2:0] ALU_XOR  = 3'b010;
   localparam logic [2:0] ALU_NOR  = 3'b011;
   localparam logic [2:0] ALU_ADD  = 3'b100;
   localparam logic [2:0] ALU_SUB  = 3'b101;
   localparam logic [2:0] ALU_SLTU = 3'b110;
   localparam logic [2:0] ALU_SLLV = 3'b111;

   // R-type function field encodings
   localparam logic [5:0] FN_AND  = 6'b100100;
   localparam logic [5:0] FN_OR   = 6'b100101;
   localparam logic [5:0] FN_XOR  = 6'b100110;
   localparam logic [5:0] FN_NOR  = 6'b100111;
   localparam logic [5:0] FN_ADD  = 6'b100000;
   localparam logic [5:0] FN_SUB  = 6'b100010;
   localparam logic [5:0] FN_SLTU = 6'b101011;
   localparam logic [5:0] FN_SLLV = 6'b000100;

   localparam logic [5:0] OP_RTYPE = 6'b000000;

   // Trap cause codes
   localparam logic [1:0] TC_NONE      = 2'b00;
   localparam logic [1:0] TC_ILLEGAL   = 2'b01;
   localparam logic [1:0] TC_FETCH_TMO = 2'b10;

   // Only the R-type opcode is executable by this core
   function automatic logic is_rtype(input logic [5:0] op);
      return (op == OP_RTYPE);
   endfunction

endpackage

// File: rtl/r_cpu_ctrl_func_dec.sv
// Combinational func-field decoder: maps a supported R-type func code to its
// ALU operation and flags every other encoding as illegal.
module r_cpu_ctrl_func_dec
   import r_cpu_ctrl_pkg::*;
(
   input  logic [5:0] func,
   output logic       legal,
   output logic [2:0] alu_op
);

   // Table lookup; unsupported codes fall through as illegal with a benign op
   always_comb begin
      legal  = 1'b1;
      alu_op = ALU_AND;
      case (func)
         FN_AND:  alu_op = ALU_AND;
         FN_OR:   alu_op = ALU_OR;
         FN_XOR:  alu_op = ALU_XOR;
         FN_NOR:  alu_op = ALU_NOR;
         FN_ADD:  alu_op = ALU_ADD;
         FN_SUB:  alu_op = ALU_SUB;
         FN_SLTU: alu_op = ALU_SLTU;
         FN_SLLV: alu_op = ALU_SLLV;
         default: legal  = 1'b0;
      endcase
   end

endmodule

// File: rtl/r_cpu_ctrl.sv
// Multi-cycle control unit for the R-type CPU datapath. Walks each instruction
// through FETCH/DECODE/EXEC/WB, drives the datapath write enables, decodes the
// ALU operation and traps on illegal encodings or instruction-fetch timeout.
module r_cpu_ctrl
   import r_cpu_ctrl_pkg::*;
#(
   parameter int RET_W     = 16,
   parameter int FETCH_TMO = 8
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic [5:0]       OP,
   input  logic [5:0]       func,
   input  logic             imem_ack,
   output logic             imem_req,
   output logic             pc_we,
   output logic             ir_we,
   output logic             ab_we,
   output logic             fr_we,
   output logic             rf_we,
   output logic [2:0]       alu_op,
   output logic             busy,
   output logic             trap,
   output logic [1:0]       trap_cause,
   output logic [RET_W-1:0] retired
);

   // Last FETCH cycle index before the timeout trap fires
   localparam logic [7:0] TMO_LAST = 8'(FETCH_TMO - 1);

   state_t           state;
   logic [7:0]       tmo_cnt;
   logic [2:0]       alu_op_q;
   logic [1:0]       cause_q;
   logic [RET_W-1:0] ret_q;
   logic             req_q;
   logic             ab_q;
   logic             fr_q;
   logic             rf_q;
   logic             busy_q;
   logic             trap_q;

   logic             dec_legal;
   logic [2:0]       dec_op;
   logic             fetch_done;

   r_cpu_ctrl_func_dec u_func_dec (
      .func   (func),
      .legal  (dec_legal),
      .alu_op (dec_op)
   );

   // IR/PC load is the only Mealy output: it follows the memory handshake
   assign fetch_done = (state == ST_FETCH) && imem_ack;

   // Sequencer: state, counters and registered per-state outputs. Each output
   // register is loaded with the value belonging to the state being entered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         tmo_cnt  <= '0;
         alu_op_q <= ALU_AND;
         cause_q  <= TC_NONE;
         ret_q    <= '0;
         req_q    <= 1'b0;
         ab_q     <= 1'b0;
         fr_q     <= 1'b0;
         rf_q     <= 1'b0;
         busy_q   <= 1'b0;
         trap_q   <= 1'b0;
      end else begin
         req_q  <= 1'b0;
         ab_q   <= 1'b0;
         fr_q   <= 1'b0;
         rf_q   <= 1'b0;
         busy_q <= 1'b0;
         trap_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (run) begin
                  state  <= ST_FETCH;
                  req_q  <= 1'b1;
                  busy_q <= 1'b1;
               end
            end
            ST_FETCH: begin
               if (imem_ack) begin
                  tmo_cnt <= '0;
                  state   <= ST_DECODE;
                  ab_q    <= 1'b1;
                  busy_q  <= 1'b1;
               end else if (tmo_cnt == TMO_LAST) begin
                  tmo_cnt <= '0;
                  cause_q <= TC_FETCH_TMO;
                  state   <= ST_TRAP;
                  trap_q  <= 1'b1;
               end else begin
                  tmo_cnt <= tmo_cnt + 8'd1;
                  req_q   <= 1'b1;
                  busy_q  <= 1'b1;
               end
            end
            ST_DECODE: begin
               if (is_rtype(OP) && dec_legal) begin
                  alu_op_q <= dec_op;
                  state    <= ST_EXEC;
                  fr_q     <= 1'b1;
                  busy_q   <= 1'b1;
               end else begin
                  cause_q <= TC_ILLEGAL;
                  state   <= ST_TRAP;
                  trap_q  <= 1'b1;
               end
            end
            ST_EXEC: begin
               state  <= ST_WB;
               rf_q   <= 1'b1;
               busy_q <= 1'b1;
            end
            ST_WB: begin
               ret_q <= ret_q + RET_W'(1);
               if (run) begin
                  state  <= ST_FETCH;
                  req_q  <= 1'b1;
                  busy_q <= 1'b1;
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_TRAP: begin
               state  <= ST_TRAP;
               trap_q <= 1'b1;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign imem_req   = req_q;
   assign pc_we      = fetch_done;
   assign ir_we      = fetch_done;
   assign ab_we      = ab_q;
   assign fr_we      = fr_q;
   assign rf_we      = rf_q;
   assign alu_op     = alu_op_q;
   assign busy       = busy_q;
   assign trap       = trap_q;
   assign trap_cause = cause_q;
   assign retired    = ret_q;

endmodule

// File: tb/tb_r_cpu_ctrl.sv
// Bench for r_cpu_ctrl: drives whole instructions (random fetch waits, random
// func/OP, random run drops) and compares every cycle against the expected
// per-instruction output schedule derived from the instruction's fields.
module tb_r_cpu_ctrl;

   localparam int RW  = 4;
   localparam int TMO = 8;

   // Expected output flag bits: {imem_req, pc_we, ir_we, ab_we, fr_we, rf_we, busy, trap}
   localparam logic [7:0] F_REQ  = 8'h80;
   localparam logic [7:0] F_PCIR = 8'h60;
   localparam logic [7:0] F_AB   = 8'h10;
   localparam logic [7:0] F_FR   = 8'h08;
   localparam logic [7:0] F_RF   = 8'h04;
   localparam logic [7:0] F_BUSY = 8'h02;
   localparam logic [7:0] F_TRAP = 8'h01;

   logic          clk = 1'b0;
   logic          rst;
   logic          run;
   logic [5:0]    OP;
   logic [5:0]    func;
   logic          imem_ack;
   logic          imem_req, pc_we, ir_we, ab_we, fr_we, rf_we, busy, trap;
   logic [2:0]    alu_op;
   logic [1:0]    trap_cause;
   logic [RW-1:0] retired;

   always #5 clk = ~clk;

   r_cpu_ctrl #(.RET_W(RW), .FETCH_TMO(TMO)) dut (
      .clk        (clk),
      .rst        (rst),
      .run        (run),
      .OP         (OP),
      .func       (func),
      .imem_ack   (imem_ack),
      .imem_req   (imem_req),
      .pc_we      (pc_we),
      .ir_we      (ir_we),
      .ab_we      (ab_we),
      .fr_we      (fr_we),
      .rf_we      (rf_we),
      .alu_op     (alu_op),
      .busy       (busy),
      .trap       (trap),
      .trap_cause (trap_cause),
      .retired    (retired)
   );

   wire [7:0] flags = {imem_req, pc_we, ir_we, ab_we, fr_we, rf_we, busy, trap};

   // Supported func codes; the position in the table is the ALU op code
   logic [5:0] fn_tab [8] = '{6'b100100, 6'b100101, 6'b100110, 6'b100111,
                              6'b100000, 6'b100010, 6'b101011, 6'b000100};

   int total = 0;
   int bad   = 0;

   // Reference state
   int exp_ret   = 0;
   int exp_cause = 0;
   int exp_alu   = 0;
   bit in_fetch  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", tag, got, want);
      end
   endtask

   function automatic int ref_alu(input logic [5:0] f);
      for (int i = 0; i < 8; i++)
         if (fn_tab[i] == f) return i;
      return -1;
   endfunction

   // One clock cycle: sample at the falling edge, return just after the rising edge
   task automatic cyc(input string tag, input logic [7:0] ef, input bit chk_alu);
      @(negedge clk);
      check({tag, ".en"}, 32'(flags), 32'(ef));
      check({tag, ".ret"}, 32'(retired), exp_ret);
      check({tag, ".cause"}, 32'(trap_cause), exp_cause);
      if (chk_alu) check({tag, ".alu"}, 32'(alu_op), exp_alu);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      run = 1'b0;
      imem_ack = 1'b0;
      OP = 6'd0;
      func = 6'd0;
      exp_ret = 0;
      exp_cause = 0;
      exp_alu = 0;
      cyc("rst0", 8'h00, 1'b1);
      cyc("rst1", 8'h00, 1'b1);
      rst = 1'b0;
      in_fetch = 0;
   endtask

   task automatic enter_fetch();
      int n;
      if (!in_fetch) begin
         run = 1'b0;
         n = $urandom_range(0, 2);
         for (int i = 0; i < n; i++) cyc("idle", 8'h00, 1'b0);
         run = 1'b1;
         cyc("idle_go", 8'h00, 1'b0);
         in_fetch = 1;
      end
   endtask

   // One full instruction from its first FETCH cycle onward
   task automatic do_instr(input int waits, input logic [5:0] op, input logic [5:0] fn,
                           input bit keep_run, output bit trapped);
      int a;
      trapped = 0;
      enter_fetch();
      OP = op;
      func = fn;
      run = 1'b1;
      for (int i = 0; i < waits && i < TMO; i++) begin
         imem_ack = 1'b0;
         cyc("wait", F_REQ | F_BUSY, 1'b0);
      end
      if (waits >= TMO) begin
         exp_cause = 2;
         cyc("tmo", F_TRAP, 1'b0);
         trapped = 1;
         in_fetch = 0;
         return;
      end
      imem_ack = 1'b1;
      cyc("ack", F_REQ | F_PCIR | F_BUSY, 1'b0);
      imem_ack = 1'($urandom_range(0, 1));
      cyc("dec", F_AB | F_BUSY, 1'b0);
      a = ref_alu(fn);
      if (op != 6'd0 || a < 0) begin
         exp_cause = 1;
         cyc("ill", F_TRAP, 1'b0);
         trapped = 1;
         in_fetch = 0;
         return;
      end
      exp_alu = a;
      run = keep_run;
      cyc("exe", F_FR | F_BUSY, 1'b1);
      cyc("wb", F_RF | F_BUSY, 1'b1);
      exp_ret = (exp_ret + 1) % (1 << RW);
      in_fetch = keep_run;
      if (!keep_run) cyc("idle_end", 8'h00, 1'b1);
   endtask

   task automatic trap_hold(input int n);
      for (int i = 0; i < n; i++) begin
         run = 1'($urandom_range(0, 1));
         imem_ack = 1'($urandom_range(0, 1));
         cyc("trap_hold", F_TRAP, 1'b0);
      end
   endtask

   initial begin
      bit tr;
      int w, k, op_i, fn_i;
      logic [5:0] fn;
      logic [5:0] op;

      do_reset();

      // Zero-wait ADD stream: retired 0 -> 1 -> 2
      do_instr(0, 6'd0, 6'b100000, 1'b1, tr);
      check("ret_after_1", 32'(retired), 1);
      do_instr(0, 6'd0, 6'b100000, 1'b1, tr);
      check("ret_after_2", 32'(retired), 2);

      // All legal funcs
      for (int i = 0; i < 8; i++) do_instr(0, 6'd0, fn_tab[i], 1'b1, tr);

      // Ack after three waits
      do_instr(3, 6'd0, 6'b100010, 1'b1, tr);
      check("wait3_no_trap", 32'(tr), 0);

      // run dropped in EXEC: completes, then IDLE
      do_instr(0, 6'd0, 6'b100010, 1'b0, tr);

      // Illegal func
      do_instr(0, 6'd0, 6'b001000, 1'b1, tr);
      check("ill_func_trap", 32'(tr), 1);
      trap_hold(4);
      do_reset();

      // Non-R-type opcode
      do_instr(0, 6'b000010, 6'b100000, 1'b1, tr);
      check("ill_op_trap", 32'(tr), 1);
      trap_hold(3);
      do_reset();

      // Fetch timeout
      do_instr(TMO + 3, 6'd0, 6'b100000, 1'b1, tr);
      check("tmo_trap", 32'(tr), 1);
      trap_hold(3);
      do_reset();

      // Asynchronous reset mid-EXEC
      do_instr(0, 6'd0, 6'b100000, 1'b1, tr);
      do_instr(0, 6'd0, 6'b100101, 1'b1, tr);
      OP = 6'd0;
      func = 6'b100000;
      imem_ack = 1'b1;
      cyc("ar_ack", F_REQ | F_PCIR | F_BUSY, 1'b0);
      cyc("ar_dec", F_AB | F_BUSY, 1'b0);
      #2;
      check("ar_fr_before", 32'(fr_we), 1);
      rst = 1'b1;
      #1;
      check("ar_fr_after", 32'(fr_we), 0);
      check("ar_busy_after", 32'(busy), 0);
      check("ar_ret_after", 32'(retired), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      run = 1'b0;
      imem_ack = 1'b0;
      exp_ret = 0;
      exp_cause = 0;
      exp_alu = 0;
      in_fetch = 0;
      cyc("ar_idle", 8'h00, 1'b1);

      // Counter wrap with RET_W=4
      for (int i = 0; i < 17; i++) begin
         k = $urandom_range(0, 7);
         do_instr(0, 6'd0, fn_tab[k], 1'b1, tr);
      end
      check("ret_wrap", 32'(retired), 1);

      // Randomized instruction mix
      for (int n = 0; n < 60; n++) begin
         w = ($urandom_range(0, 15) == 0) ? TMO : $urandom_range(0, 4);
         if ($urandom_range(0, 3) != 0) begin
            fn_i = $urandom_range(0, 7);
            fn = fn_tab[fn_i];
         end else begin
            fn = 6'($urandom);
         end
         op_i = ($urandom_range(0, 15) == 0) ? $urandom_range(1, 63) : 0;
         op = 6'(op_i);
         do_instr(w, op, fn, ($urandom_range(0, 3) != 0), tr);
         if (tr) begin
            trap_hold(2);
            do_reset();
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "watchdog");
   end

endmodule
